// File: rtl/tick_scheduler_pkg.sv
// Shared types and defaults for the tick scheduler.
// State encodings are visible on the state output port.
package tick_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_STEP  = 2'd3
   } state_t;

   localparam int DEF_DIV = 1;

endpackage

// File: rtl/tick_scheduler_if.sv
// Config port: valid/ready transfer of a channel divisor.
// The scheduler is the slave; the programming side is the master.
interface tick_scheduler_if #(
   parameter int CH_W  = 2,
   parameter int DIV_W = 32
);
   logic             valid;
   logic             ready;
   logic [CH_W-1:0]  ch;
   logic [DIV_W-1:0] div;

   modport master (output valid, ch, div, input ready);
   modport slave  (input valid, ch, div, output ready);
endinterface

// File: rtl/tick_scheduler_counter.sv
// One tick channel: counter, live divisor, shadow divisor
// and the registered one-cycle tick strobe.
module tick_counter #(
   parameter int               DIV_W   = 32,
   parameter logic [DIV_W-1:0] RST_DIV = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             advance,
   input  logic             clear,
   input  logic             load_now,
   input  logic             load_shadow,
   input  logic [DIV_W-1:0] din,
   output logic             tick,
   output logic             pending
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div_reg;
   logic [DIV_W-1:0] shadow;

   // Wrap uses >= so a divisor shrunk while paused
   // cannot strand the count above it.
   logic wrap;
   assign wrap = (cnt >= div_reg);

   // Count advance edges, strobe on wrap, swap in a
   // deferred divisor at a wrap or once advancing stops.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         div_reg <= RST_DIV;
         shadow  <= '0;
         pending <= 1'b0;
         tick    <= 1'b0;
      end else begin
         tick <= 1'b0;
         if (advance) begin
            if (wrap) begin
               cnt  <= '0;
               tick <= 1'b1;
               if (pending) begin
                  div_reg <= shadow;
                  pending <= 1'b0;
               end
            end else begin
               cnt <= cnt + DIV_W'(1);
            end
         end else begin
            if (pending) begin
               div_reg <= shadow;
               pending <= 1'b0;
            end
            if (clear) cnt <= '0;
         end
         if (load_now) div_reg <= din;
         if (load_shadow) begin
            shadow  <= din;
            pending <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/tick_scheduler.sv
// Clock-enable scheduler: NUM_CH tick strobes sequenced by
// a run/pause/step FSM, with runtime-retunable periods.
module tick_scheduler
   import tick_sched_pkg::*;
#(
   parameter int NUM_CH  = 4,
   parameter int DIV_W   = 32,
   parameter int CH_W    = 2,
   parameter int DEF_DIV = tick_sched_pkg::DEF_DIV
) (
   input  logic              in_clk,
   input  logic              rst,
   input  logic              cmd_start,
   input  logic              cmd_stop,
   input  logic              cmd_step,
   tick_scheduler_if.slave   cfg,
   output logic [NUM_CH-1:0] tick,
   output logic [1:0]        state
);

   state_t            st_q;
   logic              advance;
   logic              clear;
   logic              xfer;
   logic [NUM_CH-1:0] pend_vec;

   assign advance   = (st_q == ST_RUN) || (st_q == ST_STEP);
   assign clear     = (st_q == ST_PAUSE) && cmd_stop;
   assign cfg.ready = ~|pend_vec;
   assign xfer      = cfg.valid && cfg.ready;
   assign state     = st_q;

   // Run/pause/step sequencing; stop beats step beats start.
   always_ff @(posedge in_clk) begin
      if (rst) begin
         st_q <= ST_IDLE;
      end else begin
         unique case (st_q)
            ST_IDLE: begin
               if (cmd_stop)       st_q <= ST_IDLE;
               else if (cmd_step)  st_q <= ST_STEP;
               else if (cmd_start) st_q <= ST_RUN;
            end
            ST_RUN: begin
               if (cmd_stop) st_q <= ST_PAUSE;
            end
            ST_PAUSE: begin
               if (cmd_stop)       st_q <= ST_IDLE;
               else if (cmd_step)  st_q <= ST_STEP;
               else if (cmd_start) st_q <= ST_RUN;
            end
            ST_STEP: st_q <= ST_PAUSE;
            default: st_q <= ST_IDLE;
         endcase
      end
   end

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic sel;
      assign sel = xfer && (cfg.ch == CH_W'(gi));

      tick_counter #(
         .DIV_W   (DIV_W),
         .RST_DIV (DIV_W'(DEF_DIV))
      ) u_cnt (
         .clk         (in_clk),
         .rst         (rst),
         .advance     (advance),
         .clear       (clear),
         .load_now    (sel && !advance),
         .load_shadow (sel && advance),
         .din         (cfg.div),
         .tick        (tick[gi]),
         .pending     (pend_vec[gi])
      );
   end

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler: directed scenarios
// plus randomized traffic against a behavioural model.
module tb_tick_scheduler;

   localparam int NCH = 4;
   localparam int DW  = 32;
   localparam int CW  = 2;

   logic clk = 1'b0;
   logic rst, start, stop, step;
   logic [NCH-1:0] tick;
   logic [1:0]     state;
   logic [2:0]     tick3;
   logic [1:0]     state3;

   int total = 0;
   int bad   = 0;

   tick_scheduler_if #(.CH_W(CW), .DIV_W(DW)) cif ();
   tick_scheduler_if #(.CH_W(CW), .DIV_W(DW)) cif3 ();

   assign cif3.valid = cif.valid;
   assign cif3.ch    = cif.ch;
   assign cif3.div   = cif.div;

   tick_scheduler #(
      .NUM_CH(NCH), .DIV_W(DW), .CH_W(CW), .DEF_DIV(1)
   ) u_dut (
      .in_clk(clk), .rst(rst),
      .cmd_start(start), .cmd_stop(stop), .cmd_step(step),
      .cfg(cif.slave), .tick(tick), .state(state)
   );

   tick_scheduler #(
      .NUM_CH(3), .DIV_W(DW), .CH_W(CW), .DEF_DIV(1)
   ) u_dut3 (
      .in_clk(clk), .rst(rst),
      .cmd_start(start), .cmd_stop(stop), .cmd_step(step),
      .cfg(cif3.slave), .tick(tick3), .state(state3)
   );

   always #5 clk = ~clk;

   // Behavioural model: per channel, advance edges elapsed
   // since the last tick and the period in force.
   int unsigned m_elapsed [NCH];
   int unsigned m_period  [NCH];
   int unsigned m_next    [NCH];
   bit          m_waiting [NCH];
   logic [NCH-1:0] m_tick;
   logic [1:0]     m_st;

   function automatic bit m_ready();
      bit any = 0;
      for (int c = 0; c < NCH; c++) any |= m_waiting[c];
      return !any;
   endfunction

   task automatic model_edge();
      bit running, accept;
      if (rst) begin
         m_st = 2'd0;
         m_tick = '0;
         for (int c = 0; c < NCH; c++) begin
            m_elapsed[c] = 0;
            m_period[c]  = 2;
            m_waiting[c] = 0;
         end
         return;
      end
      running = (m_st == 2'd1) || (m_st == 2'd3);
      accept  = cif.valid && m_ready();
      for (int c = 0; c < NCH; c++) begin
         m_tick[c] = 1'b0;
         if (running) begin
            if (m_elapsed[c] + 1 >= m_period[c]) begin
               m_tick[c] = 1'b1;
               m_elapsed[c] = 0;
               if (m_waiting[c]) begin
                  m_period[c] = m_next[c];
                  m_waiting[c] = 0;
               end
            end else begin
               m_elapsed[c]++;
            end
         end else begin
            if (m_waiting[c]) begin
               m_period[c] = m_next[c];
               m_waiting[c] = 0;
            end
            if (m_st == 2'd2 && stop) m_elapsed[c] = 0;
         end
      end
      if (accept && int'(cif.ch) < NCH) begin
         if (running) begin
            m_next[cif.ch] = cif.div + 1;
            m_waiting[cif.ch] = 1;
         end else begin
            m_period[cif.ch] = cif.div + 1;
         end
      end
      case (m_st)
         2'd0: if (stop) m_st = 2'd0;
               else if (step) m_st = 2'd3;
               else if (start) m_st = 2'd1;
         2'd1: if (stop) m_st = 2'd2;
         2'd2: if (stop) m_st = 2'd0;
               else if (step) m_st = 2'd3;
               else if (start) m_st = 2'd1;
         default: m_st = 2'd2;
      endcase
   endtask

   task automatic tick_clk();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      start = 0; stop = 0; step = 0;
      cif.valid = 0; cif.ch = '0; cif.div = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      tick_clk();
      tick_clk();
      rst = 0;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (tick !== 4'b0 || state !== 2'd0 || cif.ready !== 1'b1) begin
         bad++;
         $display("FAIL reset tick=%b state=%0d rdy=%b want 0000/0/1",
                  tick, state, cif.ready);
      end
   endtask

   task automatic test_start_default();
      logic [3:0] exp;
      do_reset();
      start = 1;
      tick_clk();
      start = 0;
      for (int k = 1; k <= 8; k++) begin
         tick_clk();
         exp = (k % 2 == 0) ? 4'hF : 4'h0;
         total++;
         if (tick !== exp || state !== 2'd1) begin
            bad++;
            $display("FAIL start k=%0d tick=%b state=%0d want %b/1",
                     k, tick, state, exp);
         end
      end
   endtask

   task automatic test_cfg_idle();
      logic [3:0] exp;
      do_reset();
      cif.valid = 1; cif.ch = 2'd2; cif.div = 3;
      tick_clk();
      cif.valid = 0;
      total++;
      if (cif.ready !== 1'b1 || state !== 2'd0) begin
         bad++;
         $display("FAIL cfg_idle rdy=%b state=%0d want 1/0",
                  cif.ready, state);
      end
      start = 1;
      tick_clk();
      start = 0;
      for (int k = 1; k <= 12; k++) begin
         tick_clk();
         exp = (k % 2 == 0) ? 4'b1011 : 4'b0000;
         if (k % 4 == 0) exp[2] = 1'b1;
         total++;
         if (tick !== exp) begin
            bad++;
            $display("FAIL cfg_idle k=%0d tick=%b want %b",
                     k, tick, exp);
         end
      end
   endtask

   task automatic test_retune_run();
      logic exp_t, exp_r;
      do_reset();
      cif.valid = 1; cif.ch = 2'd0; cif.div = 5;
      tick_clk();
      cif.valid = 0;
      start = 1;
      tick_clk();
      start = 0;
      for (int k = 1; k <= 10; k++) begin
         if (k == 3) begin
            cif.valid = 1; cif.ch = 2'd0; cif.div = 1;
         end
         tick_clk();
         cif.valid = 0;
         exp_t = (k == 6 || k == 8 || k == 10);
         exp_r = !(k >= 3 && k <= 5);
         total++;
         if (tick[0] !== exp_t || cif.ready !== exp_r
             || tick !== m_tick) begin
            bad++;
            $display("FAIL retune k=%0d t0=%b rdy=%b tick=%b want %b/%b/%b",
                     k, tick[0], cif.ready, tick, exp_t, exp_r, m_tick);
         end
      end
   endtask

   task automatic test_pause_step();
      logic [3:0] exp;
      do_reset();
      start = 1;
      tick_clk();
      start = 0;
      for (int k = 1; k <= 19; k++) begin
         stop  = (k == 10);
         step  = (k == 14);
         start = (k == 16);
         tick_clk();
         idle_inputs();
         exp = 4'h0;
         if (k <= 10 && k % 2 == 0) exp = 4'hF;
         if (k == 17 || k == 19) exp = 4'hF;
         total++;
         if (tick !== exp || state !== m_st) begin
            bad++;
            $display("FAIL pause_step k=%0d tick=%b st=%0d want %b/%0d",
                     k, tick, state, exp, m_st);
         end
         if (k == 14 || k == 15) begin
            total++;
            if (state !== (k == 14 ? 2'd3 : 2'd2)) begin
               bad++;
               $display("FAIL step_state k=%0d state=%0d want %0d",
                        k, state, (k == 14 ? 3 : 2));
            end
         end
      end
   endtask

   task automatic test_all_cmds();
      do_reset();
      start = 1;
      tick_clk();
      start = 0;
      for (int k = 1; k <= 7; k++) begin
         stop  = (k == 3) || (k == 4);
         step  = (k == 4);
         start = (k == 4) || (k == 5);
         tick_clk();
         idle_inputs();
         if (k == 4) begin
            total++;
            if (state !== 2'd0) begin
               bad++;
               $display("FAIL all_cmds state=%0d want 0", state);
            end
         end
         if (k == 6 || k == 7) begin
            total++;
            if (tick !== (k == 7 ? 4'hF : 4'h0)) begin
               bad++;
               $display("FAIL all_cmds_clr k=%0d tick=%b want %b",
                        k, tick, (k == 7 ? 4'hF : 4'h0));
            end
         end
      end
   endtask

   task automatic test_out_of_range();
      logic [2:0] exp;
      do_reset();
      cif.valid = 1; cif.ch = 2'd3; cif.div = 7;
      tick_clk();
      cif.valid = 0;
      total++;
      if (cif3.ready !== 1'b1) begin
         bad++;
         $display("FAIL oor_idle rdy=%b want 1", cif3.ready);
      end
      start = 1;
      tick_clk();
      start = 0;
      for (int k = 1; k <= 6; k++) begin
         cif.valid = (k == 2); cif.ch = 2'd3; cif.div = 4;
         tick_clk();
         cif.valid = 0;
         exp = (k % 2 == 0) ? 3'b111 : 3'b000;
         total++;
         if (tick3 !== exp || cif3.ready !== 1'b1) begin
            bad++;
            $display("FAIL oor_run k=%0d tick=%b rdy=%b want %b/1",
                     k, tick3, cif3.ready, exp);
         end
      end
   endtask

   task automatic test_reset_pending();
      do_reset();
      start = 1;
      tick_clk();
      start = 0;
      tick_clk();
      tick_clk();
      cif.valid = 1; cif.ch = 2'd1; cif.div = 9;
      tick_clk();
      cif.valid = 0;
      total++;
      if (cif.ready !== 1'b0) begin
         bad++;
         $display("FAIL rst_pend_pre rdy=%b want 0", cif.ready);
      end
      rst = 1;
      tick_clk();
      rst = 0;
      total++;
      if (state !== 2'd0 || tick !== 4'b0 || cif.ready !== 1'b1) begin
         bad++;
         $display("FAIL rst_pend st=%0d tick=%b rdy=%b want 0/0000/1",
                  state, tick, cif.ready);
      end
      start = 1;
      tick_clk();
      start = 0;
      for (int k = 1; k <= 4; k++) begin
         tick_clk();
         total++;
         if (tick[1] !== (k % 2 == 0)) begin
            bad++;
            $display("FAIL rst_pend_div k=%0d t1=%b want %b",
                     k, tick[1], (k % 2 == 0));
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         start     = ($urandom_range(0, 5) == 0);
         stop      = ($urandom_range(0, 9) == 0);
         step      = ($urandom_range(0, 7) == 0);
         cif.valid = ($urandom_range(0, 3) == 0);
         cif.ch    = CW'($urandom_range(0, 3));
         cif.div   = DW'($urandom_range(0, 5));
         rst       = ($urandom_range(0, 299) == 0);
         tick_clk();
         total++;
         if (tick !== m_tick || state !== m_st
             || cif.ready !== m_ready()) begin
            bad++;
            $display("FAIL random n=%0d tick=%b st=%0d rdy=%b want %b/%0d/%b",
                     n, tick, state, cif.ready, m_tick, m_st, m_ready());
         end
      end
      idle_inputs();
      rst = 0;
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      test_reset();
      test_start_default();
      test_cfg_idle();
      test_retune_run();
      test_pause_step();
      test_all_cmds();
      test_out_of_range();
      test_reset_pending();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
